router_psum_buffered: RTL and testbench
=======================================

Name: router_psum_buffered

Overview:
Second-generation west-edge psum router for the PE-cluster mesh. It replaces combinational north/west forwarding with a buffered, valid/ready-handshaked forwarding path (FIFO of full X_dim-lane psum vectors) toward south/east. It also contains a stall-aware write-back serializer that drains spad psum vectors lane-by-lane into the psum GLB, using a wrapping address counter and a completion pulse.

Parameters:
DATA_BITWIDTH, 16, bits per psum lane
X_dim, 5, lanes per psum vector
ADDR_BITWIDTH_GLB, 10, GLB address width
FIFO_DEPTH, 4, forwarding FIFO entries (power of 2, >=2)
PSUM_LOAD_ADDR, 0, first GLB write address
PSUM_WORDS, 15, GLB words per pass before the address wraps (1..2^ADDR_BITWIDTH_GLB-PSUM_LOAD_ADDR)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
router_mode  in  4  routing mode (values from the shared package)
north_data_i  in  DATA_BITWIDTH*X_dim  psum vector from north
north_valid_i  in  1  north vector valid
north_ready_o  out  1  north vector accepted
west_data_i  in  DATA_BITWIDTH*X_dim  psum vector from west
west_valid_i  in  1  west vector valid
west_ready_o  out  1  west vector accepted
south_data_o  out  DATA_BITWIDTH*X_dim  vector to south
south_valid_o  out  1  south valid
south_ready_i  in  1  south ready
east_data_o  out  DATA_BITWIDTH*X_dim  vector to east
east_valid_o  out  1  east valid
east_ready_i  in  1  east ready
spad_data_i  in  DATA_BITWIDTH*X_dim  psum vector from PE spads
spad_valid_i  in  1  spad vector valid
spad_ready_o  out  1  serializer can accept a vector
glb_stall_i  in  1  GLB cannot accept a write this cycle
glb_w_en_o  out  1  GLB write enable
glb_w_data_o  out  DATA_BITWIDTH  GLB write data
glb_w_addr_o  out  ADDR_BITWIDTH_GLB  GLB write address
wb_done_o  out  1  one-cycle pulse after the final write of a pass

Behaviour:
- Reset (async, any time, including mid-operation): FIFO emptied; serializer to IDLE; address counter = PSUM_LOAD_ADDR. All valid, ready, enable and pulse outputs = 0; data outputs = 0.
- Forwarding is enabled only in SOUTH(2), EAST(4) and EASTSOUTH(6). Every other value, including CLOSED(11), behaves as CLOSED: no enqueue, no dequeue, all forward valids and readies = 0, and FIFO contents are retained.
- Source select: north has priority over west. north_ready_o = enabled & !full. west_ready_o = enabled & !full & !north_valid_i. At most one enqueue per cycle.
- Push when the selected valid & ready. A word pushed at edge t is at the head (outputs valid) from cycle t+1. Minimum latency is 1 cycle.
- Head outputs: south_valid_o = !empty & mode∈{SOUTH,EASTSOUTH}; east_valid_o = !empty & mode∈{EAST,EASTSOUTH}. The data of an inactive direction is driven 0.
- Pop when every active direction has valid & ready. In EASTSOUTH, both ready inputs must be high in the same cycle (no partial delivery).
- Full with a simultaneous pop: ready stays low (ready = !full, registered count). Empty with a push: no bypass.
- Serializer FSM:
  - IDLE: spad_ready_o = 1. On spad_valid_i, capture the vector, set lane = 0, go to SHIFT.
  - SHIFT: spad_ready_o = 0. glb_w_en_o = !glb_stall_i, glb_w_data_o = lane[lane] (lane 0 = bits DATA_BITWIDTH-1:0), glb_w_addr_o = counter. On each non-stalled cycle: lane++, counter++. After lane X_dim-1 is written, go to IDLE.
  - Throughput: X_dim+1 cycles per vector with no stalls.
- Stalls hold lane, address and data unchanged.
- Address wrap: the write at PSUM_LOAD_ADDR+PSUM_WORDS-1 is followed by counter = PSUM_LOAD_ADDR. wb_done_o pulses in the cycle after that write. A wrap may fall mid-vector; the serialization continues across it.
- Serializer operation is independent of router_mode.

Decomposition:
- Package router_pkg: mode constants ALL..CLOSED (0..11), serializer state encoding (IDLE, SHIFT), and a helper function for log2 of FIFO_DEPTH.
- One sub-module, psum_vec_fifo: synchronous FIFO parametrised by width and depth, with full/empty/count outputs.

Test Plan:
- Mode SOUTH, north vector 0x0001..0x0005 valid for 1 cycle, south_ready_i = 1 -> south_valid_o high next cycle with identical data; east_valid_o = 0.
- Mode EASTSOUTH, 4 west pushes with east_ready_i = 0 -> west_ready_o drops after the 4th push; after east_ready_i = 1, all 4 pop in order, one per cycle.
- north_valid_i and west_valid_i both high -> north enqueued, west_ready_o = 0; west accepted the following cycle.
- Spad vector {5,4,3,2,1}, no stall -> glb writes 1,2,3,4,5 at addresses 0..4, then spad_ready_o = 1.
- glb_stall_i high for 2 cycles during lane 2 -> lane 2 data and address are held, and total writes = 5.
- 3 vectors with PSUM_WORDS = 15 -> the 15th write goes to address 14, wb_done_o pulses once, and the next write goes to address 0. Separately, asserting reset mid-SHIFT returns all outputs to 0 immediately.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the buffered psum router: routing modes,
// serializer state encoding and a depth-to-pointer-width helper.
package router_pkg;

    localparam logic [3:0] MODE_ALL        = 4'd0;
    localparam logic [3:0] MODE_NORTH      = 4'd1;
    localparam logic [3:0] MODE_SOUTH      = 4'd2;
    localparam logic [3:0] MODE_WEST       = 4'd3;
    localparam logic [3:0] MODE_EAST       = 4'd4;
    localparam logic [3:0] MODE_NORTHSOUTH = 4'd5;
    localparam logic [3:0] MODE_EASTSOUTH  = 4'd6;
    localparam logic [3:0] MODE_NORTHWEST  = 4'd7;
    localparam logic [3:0] MODE_WESTEAST   = 4'd8;
    localparam logic [3:0] MODE_NORTHEAST  = 4'd9;
    localparam logic [3:0] MODE_WESTSOUTH  = 4'd10;
    localparam logic [3:0] MODE_CLOSED     = 4'd11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    function automatic int fifo_ptr_w(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_vec_fifo.sv
// Synchronous FIFO of whole psum vectors; pushes while full and
// pops while empty are ignored.
module psum_vec_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [fifo_ptr_w(DEPTH):0]   o_count
);

    localparam int AW = fifo_ptr_w(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/router_psum_buffered.sv
// West-edge psum router: buffered north/west -> south/east forwarding
// plus a stall-aware lane-by-lane write-back serializer into the GLB.
module router_psum_buffered
    import router_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int X_dim             = 5,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int FIFO_DEPTH        = 4,
    parameter int PSUM_LOAD_ADDR    = 0,
    parameter int PSUM_WORDS        = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     router_mode,
    input  logic [DATA_BITWIDTH*X_dim-1:0] north_data_i,
    input  logic                           north_valid_i,
    output logic                           north_ready_o,
    input  logic [DATA_BITWIDTH*X_dim-1:0] west_data_i,
    input  logic                           west_valid_i,
    output logic                           west_ready_o,
    output logic [DATA_BITWIDTH*X_dim-1:0] south_data_o,
    output logic                           south_valid_o,
    input  logic                           south_ready_i,
    output logic [DATA_BITWIDTH*X_dim-1:0] east_data_o,
    output logic                           east_valid_o,
    input  logic                           east_ready_i,
    input  logic [DATA_BITWIDTH*X_dim-1:0] spad_data_i,
    input  logic                           spad_valid_i,
    output logic                           spad_ready_o,
    input  logic                           glb_stall_i,
    output logic                           glb_w_en_o,
    output logic [DATA_BITWIDTH-1:0]       glb_w_data_o,
    output logic [ADDR_BITWIDTH_GLB-1:0]   glb_w_addr_o,
    output logic                           wb_done_o
);

    localparam int VW     = DATA_BITWIDTH * X_dim;
    localparam int CW     = fifo_ptr_w(FIFO_DEPTH) + 1;
    localparam int LANE_W = (X_dim > 1) ? $clog2(X_dim) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(X_dim - 1);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] ADDR_FIRST =
        ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] ADDR_LAST =
        ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR + PSUM_WORDS - 1);

    logic          w_run;
    logic          w_en;
    logic          w_s_act;
    logic          w_e_act;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_head;
    logic          w_src_rdy;
    logic          w_push;
    logic          w_pop;
    logic [VW-1:0] w_push_data;
    logic [VW-1:0] w_head_data;

    // Ready outputs must read 0 while reset is held, not just after it.
    assign w_run   = !reset;
    assign w_s_act = (router_mode == MODE_SOUTH) ||
                     (router_mode == MODE_EASTSOUTH);
    assign w_e_act = (router_mode == MODE_EAST) ||
                     (router_mode == MODE_EASTSOUTH);
    assign w_en    = w_s_act || w_e_act;

    assign w_src_rdy   = w_run && w_en && !w_full;
    assign w_push      = w_src_rdy && (north_valid_i || west_valid_i);
    assign w_push_data = north_valid_i ? north_data_i : west_data_i;
    assign w_head      = (w_count != '0);

    assign north_ready_o = w_src_rdy;
    assign west_ready_o  = w_src_rdy && !north_valid_i;

    assign south_valid_o = w_head && w_s_act;
    assign east_valid_o  = w_head && w_e_act;
    assign south_data_o  = south_valid_o ? w_head_data : '0;
    assign east_data_o   = east_valid_o ? w_head_data : '0;

    // EASTSOUTH pops only when both sinks take the word together.
    assign w_pop = w_en && !w_empty &&
                   (!w_s_act || south_ready_i) &&
                   (!w_e_act || east_ready_i);

    psum_vec_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    ser_state_t                   r_state;
    ser_state_t                   w_state_nxt;
    logic [VW-1:0]                r_vec;
    logic [LANE_W-1:0]            r_lane;
    logic [ADDR_BITWIDTH_GLB-1:0] r_addr;
    logic                         r_done;
    logic                         w_wr;
    logic                         w_idle;
    logic                         w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_idle      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_idle = 1'b1;
                if (spad_valid_i) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_wr = !glb_stall_i;
                if (w_wr && r_lane == LANE_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = w_idle && spad_valid_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_lane  <= '0;
            r_addr  <= ADDR_FIRST;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_wr && (r_addr == ADDR_LAST);
            if (w_accept) begin
                r_vec  <= spad_data_i;
                r_lane <= '0;
            end
            if (w_wr) begin
                r_lane <= r_lane + 1'b1;
                r_addr <= (r_addr == ADDR_LAST) ? ADDR_FIRST
                                                : r_addr + 1'b1;
            end
        end
    end

    assign spad_ready_o = w_run && w_idle;
    assign glb_w_en_o   = w_wr;
    assign glb_w_data_o = (r_state == S_SHIFT)
        ? r_vec[int'(r_lane)*DATA_BITWIDTH +: DATA_BITWIDTH] : '0;
    assign glb_w_addr_o = (r_state == S_SHIFT) ? r_addr : '0;
    assign wb_done_o    = r_done;

endmodule

// File: tb/tb_router_psum_buffered.sv
// Bench for router_psum_buffered: directed and random stimulus checked
// every cycle against a queue-based behavioural model.
module tb_router_psum_buffered;

    localparam int DW    = 16;
    localparam int XD    = 5;
    localparam int AW    = 10;
    localparam int VW    = DW * XD;
    localparam int DEPTH = 4;
    localparam int PW    = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    router_mode;
    logic [VW-1:0] north_data_i;
    logic          north_valid_i;
    logic          north_ready_o;
    logic [VW-1:0] west_data_i;
    logic          west_valid_i;
    logic          west_ready_o;
    logic [VW-1:0] south_data_o;
    logic          south_valid_o;
    logic          south_ready_i;
    logic [VW-1:0] east_data_o;
    logic          east_valid_o;
    logic          east_ready_i;
    logic [VW-1:0] spad_data_i;
    logic          spad_valid_i;
    logic          spad_ready_o;
    logic          glb_stall_i;
    logic          glb_w_en_o;
    logic [DW-1:0] glb_w_data_o;
    logic [AW-1:0] glb_w_addr_o;
    logic          wb_done_o;

    always #5 clk = ~clk;

    router_psum_buffered dut (
        .clk           (clk),
        .reset         (reset),
        .router_mode   (router_mode),
        .north_data_i  (north_data_i),
        .north_valid_i (north_valid_i),
        .north_ready_o (north_ready_o),
        .west_data_i   (west_data_i),
        .west_valid_i  (west_valid_i),
        .west_ready_o  (west_ready_o),
        .south_data_o  (south_data_o),
        .south_valid_o (south_valid_o),
        .south_ready_i (south_ready_i),
        .east_data_o   (east_data_o),
        .east_valid_o  (east_valid_o),
        .east_ready_i  (east_ready_i),
        .spad_data_i   (spad_data_i),
        .spad_valid_i  (spad_valid_i),
        .spad_ready_o  (spad_ready_o),
        .glb_stall_i   (glb_stall_i),
        .glb_w_en_o    (glb_w_en_o),
        .glb_w_data_o  (glb_w_data_o),
        .glb_w_addr_o  (glb_w_addr_o),
        .wb_done_o     (wb_done_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: forwarding buffer as a queue of vectors, write-back as a
    // queue of pending lane words plus a running count of GLB writes.
    logic [VW-1:0] q[$];
    logic [DW-1:0] wq[$];
    int            wcount = 0;
    bit            m_done = 0;
    int            writes_seen = 0;
    int            done_seen = 0;

    task automatic chk(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int i = 0; i < XD; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [VW-1:0] seqvec(input int base);
        logic [VW-1:0] v;
        for (int i = 0; i < XD; i++) v[i*DW +: DW] = DW'(base + i);
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".north_ready"}, north_ready_o, '0);
        chk({tag, ".west_ready"}, west_ready_o, '0);
        chk({tag, ".south_valid"}, south_valid_o, '0);
        chk({tag, ".south_data"}, south_data_o, '0);
        chk({tag, ".east_valid"}, east_valid_o, '0);
        chk({tag, ".east_data"}, east_data_o, '0);
        chk({tag, ".spad_ready"}, spad_ready_o, '0);
        chk({tag, ".glb_en"}, glb_w_en_o, '0);
        chk({tag, ".glb_data"}, glb_w_data_o, '0);
        chk({tag, ".glb_addr"}, glb_w_addr_o, '0);
        chk({tag, ".wb_done"}, wb_done_o, '0);
    endtask

    task automatic cycle();
        bit en, sa, ea, full, empty, nr, wr, pop, sv, ev, busy;
        logic [VW-1:0] pdata;
        @(negedge clk);
        en    = router_mode inside {4'd2, 4'd4, 4'd6};
        sa    = (router_mode == 4'd2) || (router_mode == 4'd6);
        ea    = (router_mode == 4'd4) || (router_mode == 4'd6);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        nr    = en && !full;
        wr    = nr && !north_valid_i;
        sv    = !empty && sa;
        ev    = !empty && ea;
        busy  = (wq.size() != 0);
        chk("north_ready", north_ready_o, nr);
        chk("west_ready", west_ready_o, wr);
        chk("south_valid", south_valid_o, sv);
        chk("east_valid", east_valid_o, ev);
        chk("south_data", south_data_o, sv ? q[0] : '0);
        chk("east_data", east_data_o, ev ? q[0] : '0);
        chk("spad_ready", spad_ready_o, !busy);
        chk("glb_en", glb_w_en_o, busy && !glb_stall_i);
        chk("glb_data", glb_w_data_o, busy ? wq[0] : '0);
        chk("glb_addr", glb_w_addr_o, busy ? VW'(wcount % PW) : '0);
        chk("wb_done", wb_done_o, m_done);
        if (glb_w_en_o) writes_seen++;
        if (wb_done_o) done_seen++;
        pop   = en && !empty && (!sa || south_ready_i) &&
                (!ea || east_ready_i);
        pdata = north_valid_i ? north_data_i : west_data_i;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (nr && (north_valid_i || west_valid_i)) q.push_back(pdata);
        m_done = 0;
        if (busy && !glb_stall_i) begin
            void'(wq.pop_front());
            if (wcount % PW == PW - 1) m_done = 1;
            wcount++;
        end else if (!busy && spad_valid_i) begin
            for (int i = 0; i < XD; i++) wq.push_back(spad_data_i[i*DW +: DW]);
        end
        #1;
    endtask

    task automatic idle_inputs();
        north_valid_i = 0;
        west_valid_i  = 0;
        spad_valid_i  = 0;
        glb_stall_i   = 0;
    endtask

    logic [3:0] en_modes [3] = '{4'd2, 4'd4, 4'd6};

    initial begin
        reset         = 1;
        router_mode   = 4'd11;
        north_data_i  = '0;
        west_data_i   = '0;
        spad_data_i   = '0;
        south_ready_i = 0;
        east_ready_i  = 0;
        idle_inputs();
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
        cycle();

        router_mode   = 4'd2;
        south_ready_i = 1;
        north_data_i  = seqvec(1);
        north_valid_i = 1;
        cycle();
        north_valid_i = 0;
        for (int i = 0; i < 3; i++) cycle();

        router_mode   = 4'd6;
        east_ready_i  = 0;
        west_valid_i  = 1;
        for (int i = 0; i < 5; i++) begin
            west_data_i = seqvec(16 * (i + 1));
            cycle();
        end
        chk("fill_level", west_ready_o, '0);
        west_valid_i = 0;
        east_ready_i = 1;
        for (int i = 0; i < 6; i++) cycle();

        router_mode   = 4'd2;
        south_ready_i = 0;
        north_data_i  = rvec();
        west_data_i   = rvec();
        north_valid_i = 1;
        west_valid_i  = 1;
        cycle();
        north_valid_i = 0;
        cycle();
        west_valid_i  = 0;
        router_mode   = 4'd11;
        south_ready_i = 1;
        cycle();
        router_mode   = 4'd2;
        for (int i = 0; i < 4; i++) cycle();

        spad_data_i  = seqvec(1);
        spad_valid_i = 1;
        cycle();
        spad_valid_i = 0;
        for (int i = 0; i < 6; i++) cycle();
        chk("vec1_writes", VW'(writes_seen), VW'(5));

        spad_data_i  = rvec();
        spad_valid_i = 1;
        cycle();
        spad_valid_i = 0;
        cycle();
        cycle();
        glb_stall_i = 1;
        cycle();
        cycle();
        glb_stall_i = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("vec2_writes", VW'(writes_seen), VW'(10));

        spad_data_i  = rvec();
        spad_valid_i = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            spad_valid_i = 0;
        end
        spad_data_i  = rvec();
        spad_valid_i = 1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            spad_valid_i = 0;
        end
        chk("wrap_done_count", VW'(done_seen), VW'(1));

        for (int n = 0; n < 600; n++) begin
            if (n % 8 == 0) begin
                if ($urandom_range(0, 9) < 7)
                    router_mode = en_modes[$urandom_range(0, 2)];
                else
                    router_mode = 4'($urandom_range(0, 15));
            end
            north_valid_i = ($urandom_range(0, 2) == 0);
            west_valid_i  = ($urandom_range(0, 1) == 0);
            north_data_i  = rvec();
            west_data_i   = rvec();
            south_ready_i = ($urandom_range(0, 3) != 0);
            east_ready_i  = ($urandom_range(0, 3) != 0);
            spad_valid_i  = ($urandom_range(0, 1) == 0);
            spad_data_i   = rvec();
            glb_stall_i   = ($urandom_range(0, 3) == 0);
            cycle();
        end

        idle_inputs();
        router_mode   = 4'd4;
        east_ready_i  = 0;
        north_data_i  = rvec();
        north_valid_i = 1;
        cycle();
        north_valid_i = 0;
        spad_data_i   = rvec();
        spad_valid_i  = 1;
        cycle();
        spad_valid_i = 0;
        cycle();
        reset = 1;
        #1;
        chk_all_zero("mid_reset");
        q.delete();
        wq.delete();
        wcount = 0;
        m_done = 0;
        @(posedge clk);
        #1 reset = 0;
        east_ready_i = 1;
        for (int i = 0; i < 3; i++) cycle();
        spad_data_i  = seqvec(7);
        spad_valid_i = 1;
        cycle();
        spad_valid_i = 0;
        for (int i = 0; i < 6; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
